// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: PC-stage state encoding and architectural widths.
package riscv_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_fetch_unit_sumador.sv
// Plain W-bit adder (Sumador); the carry out is discarded, so the sum wraps modulo 2^W.
module Sumador #(
    parameter int W = 32
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] S
);

    assign S = A + B;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with imem valid/ready request, redirect, wrapping fetch counter.
// Optional macro PC_TRAP_EN: misaligned redirect targets raise a trap instead of being aligned.
module pc_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             imem_ready,
    output logic [XLEN-1:0]  pc,
    output logic             pc_valid,
    output logic [XLEN-1:0]  pc_plus4,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic             trap,
    output logic [XLEN-1:0]  trap_addr
);

    pc_state_t        state, state_next;
    logic [XLEN-1:0]  pc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;

    Sumador #(.W(XLEN)) u_pc_adder (
        .A(pc),
        .B(XLEN'(INSTR_BYTES)),
        .S(pc_plus4)
    );

    assign pc_valid = (state == RUN);
    assign accept   = pc_valid & imem_ready & ~stall;

`ifdef PC_TRAP_EN
    logic            trap_next;
    logic [XLEN-1:0] trap_addr_next;
    logic            target_aligned;

    assign target_aligned = (redirect_target[1:0] == 2'b00);

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        cnt_next       = fetch_cnt;
        trap_next      = trap;
        trap_addr_next = trap_addr;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (accept) cnt_next = fetch_cnt + CNT_W'(1);
                if (redirect_valid) begin
                    if (target_aligned) begin
                        pc_next = redirect_target;
                    end else begin
                        // PC keeps the last good address; the bad target is reported instead
                        state_next     = TRAP;
                        trap_next      = 1'b1;
                        trap_addr_next = redirect_target;
                    end
                end else if (accept) begin
                    pc_next = pc_plus4;
                end
            end
            TRAP: begin
                if (redirect_valid && target_aligned) begin
                    state_next     = RUN;
                    pc_next        = redirect_target;
                    trap_next      = 1'b0;
                    trap_addr_next = '0;
                end
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_VEC;
            fetch_cnt <= '0;
            trap      <= 1'b0;
            trap_addr <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            fetch_cnt <= cnt_next;
            trap      <= trap_next;
            trap_addr <= trap_addr_next;
        end
    end
`else
    always_comb begin
        state_next = state;
        pc_next    = pc;
        cnt_next   = fetch_cnt;
        case (state)
            BOOT: state_next = RUN;
            RUN: begin
                if (accept) cnt_next = fetch_cnt + CNT_W'(1);
                // Misaligned targets are silently word-aligned
                if (redirect_valid)  pc_next = redirect_target & ~XLEN'(3);
                else if (accept)     pc_next = pc_plus4;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= BOOT;
            pc        <= RESET_VEC;
            fetch_cnt <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            fetch_cnt <= cnt_next;
        end
    end

    assign trap      = 1'b0;
    assign trap_addr = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit; handles both PC_TRAP_EN builds.
module tb_pc_fetch_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             redirect_valid;
    logic [31:0]      redirect_target;
    logic             imem_ready;
    logic [31:0]      pc;
    logic             pc_valid;
    logic [31:0]      pc_plus4;
    logic [CNT_W-1:0] fetch_cnt;
    logic             trap;
    logic [31:0]      trap_addr;

    int passed = 0;
    int total  = 0;

    pc_fetch_unit #(.RESET_VEC(32'h0000_0000), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_ready(imem_ready),
        .pc(pc),
        .pc_valid(pc_valid),
        .pc_plus4(pc_plus4),
        .fetch_cnt(fetch_cnt),
        .trap(trap),
        .trap_addr(trap_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_core(input string tag, input logic [31:0] e_pc, input logic e_vld,
                              input logic [31:0] e_cnt);
        check({tag, " pc"}, pc, e_pc);
        check({tag, " pc_valid"}, 32'(pc_valid), 32'(e_vld));
        check({tag, " fetch_cnt"}, 32'(fetch_cnt), e_cnt);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; imem_ready = 1'b0;

        // Reset held two cycles
        step(); step();
        check_core("reset", 32'h0, 1'b0, 0);
        check("reset trap", 32'(trap), 32'h0);
        check("reset trap_addr", trap_addr, 32'h0);
        rst = 1'b0;
        step();
        check_core("boot->run", 32'h0, 1'b1, 0);

        // Sequential fetch
        imem_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq pc", pc, 32'(4 * i));
        end
        check("seq cnt", 32'(fetch_cnt), 32'd4);
        check("seq pc_plus4", pc_plus4, 32'h14);

        // Backpressure then stall
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_core("not ready", 32'h10, 1'b1, 4);
        end
        imem_ready = 1'b1; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_core("stall", 32'h10, 1'b1, 4);
        end

        // Redirect overrides stall, no count
        redirect_valid = 1'b1; redirect_target = 32'h200;
        step();
        check_core("redir stall", 32'h200, 1'b1, 4);
        // Redirect coinciding with accept: count still advances
        stall = 1'b0; redirect_target = 32'h400;
        step();
        check_core("redir accept", 32'h400, 1'b1, 5);

        // PC wrap
        stall = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        check_core("redir top", 32'hFFFF_FFFC, 1'b1, 5);
        check("top pc_plus4", pc_plus4, 32'h0);
        redirect_valid = 1'b0; stall = 1'b0;
        step();
        check_core("pc wrap", 32'h0, 1'b1, 6);

        // Counter wrap
        for (int i = 0; i < 9; i++) step();
        check_core("cnt max", 32'h24, 1'b1, 15);
        step();
        check_core("cnt wrap", 32'h28, 1'b1, 0);

        // Misaligned redirect (also an accept cycle)
        redirect_valid = 1'b1; redirect_target = 32'h0000_0102;
        step();
`ifdef PC_TRAP_EN
        check_core("trap enter", 32'h28, 1'b0, 1);
        check("trap enter trap", 32'(trap), 32'h1);
        check("trap enter addr", trap_addr, 32'h102);
        redirect_valid = 1'b0;
        step();
        check_core("trap hold", 32'h28, 1'b0, 1);
        check("trap hold trap", 32'(trap), 32'h1);
        check("trap hold addr", trap_addr, 32'h102);
        redirect_valid = 1'b1; redirect_target = 32'h300; stall = 1'b1;
        step();
        check_core("trap exit", 32'h300, 1'b1, 1);
        check("trap exit trap", 32'(trap), 32'h0);
        check("trap exit addr", trap_addr, 32'h0);
        stall = 1'b0; redirect_target = 32'h2;
        step();
        check("trap again", 32'(trap), 32'h1);
`else
        check_core("align", 32'h100, 1'b1, 1);
        check("align trap", 32'(trap), 32'h0);
        redirect_valid = 1'b0;
        step();
        check_core("align next", 32'h104, 1'b1, 2);
        redirect_valid = 1'b1; redirect_target = 32'h300; stall = 1'b1;
        step();
        check_core("redir 300", 32'h300, 1'b1, 2);
        check("redir 300 addr", trap_addr, 32'h0);
        stall = 1'b0; redirect_target = 32'h2;
        step();
        check("align low", pc, 32'h0);
`endif

        // Reset overrides everything, including a trapped state
        redirect_valid = 1'b0; rst = 1'b1;
        step();
        check_core("rst mid", 32'h0, 1'b0, 0);
        check("rst mid trap", 32'(trap), 32'h0);
        check("rst mid addr", trap_addr, 32'h0);

        // Redirect in BOOT is ignored
        rst = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h500; stall = 1'b1;
        step();
        check_core("boot redir", 32'h0, 1'b1, 0);
        redirect_valid = 1'b0; stall = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
